// File: rtl/mailbox_arb.sv
// mailbox_arb: shares one Wishbone-classic mailbox slave between two masters.
// Round-robin pointer on contention, BUSY timeout abort, one-cycle DONE turnaround.
module mailbox_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_dat_o,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr,
  input  logic        s_ack,
  input  logic [31:0] s_dat_i,
  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;
  logic        r_own;
  logic [1:0]  r_grant;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  r_ack;
  logic [1:0]  r_err;

  logic        w_start;
  logic        w_sel;
  logic        w_own_stb;
  logic        w_abort;
  logic        w_done_ok;
  logic        w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_sel     = r_ptr;
    w_abort   = 1'b0;
    w_done_ok = 1'b0;
    w_tmo     = 1'b0;
    w_own_stb = r_own ? m1_stb : m0_stb;
    case (r_state)
      IDLE: begin
        if (m0_stb || m1_stb) begin
          w_start = 1'b1;
          w_sel   = (m0_stb && m1_stb) ? r_ptr : m1_stb;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        // A withdrawn request wins over a late ack or timeout.
        if (!w_own_stb) begin
          w_abort = 1'b1;
          w_next  = DONE;
        end else if (s_ack) begin
          w_done_ok = 1'b1;
          w_next    = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo  = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= 1'b0;
      r_own   <= 1'b0;
      r_grant <= 2'b00;
      r_cnt   <= 8'd0;
      r_rdata <= 32'h0;
      r_ack   <= 2'b00;
      r_err   <= 2'b00;
      s_we    <= 1'b0;
      s_adr   <= 32'h0;
      s_dat_o <= 32'h0;
    end else begin
      r_ack <= 2'b00;
      r_err <= 2'b00;
      if (w_start) begin
        r_own   <= w_sel;
        r_grant <= w_sel ? 2'b10 : 2'b01;
        r_cnt   <= 8'd0;
        s_we    <= w_sel ? m1_we    : m0_we;
        s_adr   <= w_sel ? m1_adr   : m0_adr;
        s_dat_o <= w_sel ? m1_dat_i : m0_dat_i;
      end
      if (r_state == BUSY && w_next == BUSY) r_cnt <= r_cnt + 8'd1;
      if (w_done_ok) begin
        r_rdata      <= s_dat_i;
        r_ack[r_own] <= 1'b1;
      end
      if (w_tmo) begin
        r_rdata      <= 32'h0;
        r_ack[r_own] <= 1'b1;
        r_err[r_own] <= 1'b1;
      end
      if (w_done_ok || w_tmo || w_abort) r_ptr <= ~r_own;
      if (r_state == DONE) r_grant <= 2'b00;
    end
  end

  assign s_stb    = (r_state == BUSY);
  assign busy     = (r_state != IDLE);
  assign grant    = r_grant;
  assign m0_ack   = r_ack[0];
  assign m1_ack   = r_ack[1];
  assign m0_err   = r_err[0];
  assign m1_err   = r_err[1];
  assign m0_dat_o = r_rdata;
  assign m1_dat_o = r_rdata;

endmodule

// File: tb/tb_mailbox_arb.sv
// Self-checking bench for mailbox_arb: vector table, corner sequences and
// randomized transfers against a transaction-level model.
module tb_mailbox_arb;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_dat_i = 32'h0, m0_adr = 32'h0, m1_dat_i = 32'h0, m1_adr = 32'h0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_stb, s_we;
  logic [31:0] s_dat_o, s_adr;
  logic        s_ack = 1'b0;
  logic [31:0] s_dat_i;
  logic        busy;
  logic [1:0]  grant;

  int          slv_lat = 255;
  logic [31:0] slv_data = 32'h0;
  int          stb_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mptr = 0;

  typedef struct {
    bit          r0;
    bit          r1;
    bit          we0;
    bit          we1;
    int          lat;
    logic [31:0] rdat;
    int          exp_who;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[10];

  mailbox_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_dat_i(m0_dat_i), .m0_adr(m0_adr),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_o(m0_dat_o),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_dat_i(m1_dat_i), .m1_adr(m1_adr),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_o(m1_dat_o),
    .s_stb(s_stb), .s_we(s_we), .s_dat_o(s_dat_o), .s_adr(s_adr),
    .s_ack(s_ack), .s_dat_i(s_dat_i),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // Slave: acks for one cycle, slv_lat cycles after s_stb rises.
  assign s_dat_i = slv_data;
  always @(posedge clk) begin
    #1;
    if (s_stb) stb_cnt = stb_cnt + 1;
    else       stb_cnt = 0;
    s_ack = s_stb && (stb_cnt == slv_lat + 1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no $finish, required end of test");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r0, bit r1, bit we0, bit we1, int lat,
                              logic [31:0] rdat, int who, int cyc, bit err);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
    v.lat = lat; v.rdat = rdat;
    v.exp_who = who; v.exp_cyc = cyc; v.exp_err = err;
    v.exp_dat = err ? 32'h0 : rdat;
    return v;
  endfunction

  // Runs one transfer from IDLE; the losing master withdraws after the ack.
  task automatic xfer(input vec_t v, input string tag);
    int          cyc = -1;
    int          who = -1;
    logic        err = 1'bx;
    logic [31:0] dat = 'x;
    bit          held = 1'b1;
    bit          dual = 1'b0;
    bit          quiet;
    logic [31:0] ea, ed;
    logic        ewe;
    ea  = (v.exp_who == 1) ? m1_adr   : m0_adr;
    ed  = (v.exp_who == 1) ? m1_dat_i : m0_dat_i;
    ewe = (v.exp_who == 1) ? v.we1    : v.we0;
    m0_we = v.we0; m1_we = v.we1;
    slv_lat = v.lat; slv_data = v.rdat;
    m0_stb = v.r0; m1_stb = v.r1;
    for (int c = 0; c < 40 && cyc < 0; c++) begin
      @(negedge clk);
      if (s_stb && (s_adr !== ea || s_dat_o !== ed || s_we !== ewe)) held = 1'b0;
      if (m0_ack || m1_ack) begin
        cyc  = c;
        who  = m1_ack ? 1 : 0;
        err  = m1_ack ? m1_err : m0_err;
        dat  = m1_ack ? m1_dat_o : m0_dat_o;
        dual = m0_ack && m1_ack;
      end
      @(posedge clk); #1;
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
    @(negedge clk);
    quiet = !(m0_ack || m1_ack || m0_err || m1_err || busy);
    chk({tag, "_who"},   32'(who),     32'(v.exp_who));
    chk({tag, "_cycle"}, 32'(cyc),     32'(v.exp_cyc));
    chk({tag, "_err"},   32'(err),     32'(v.exp_err));
    chk({tag, "_dat_o"}, dat,          v.exp_dat);
    chk({tag, "_slave_held"}, 32'(held), 32'd1);
    chk({tag, "_single_ack"}, 32'(dual), 32'd0);
    chk({tag, "_pulse_then_idle"}, 32'(quiet), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic seq_contention();
    logic [1:0] g[14];
    int a0c = -1;
    int a1c = -1;
    m0_adr = 32'h10; m0_dat_i = 32'hA5A5_0001; m0_we = 1'b1;
    m1_adr = 32'h20; m1_dat_i = 32'h0BAD_F00D; m1_we = 1'b0;
    slv_lat = 1; slv_data = 32'h0000_C0DE;
    m0_stb = 1'b1; m1_stb = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      g[c] = grant;
      if (m0_ack && a0c < 0) a0c = c;
      if (m1_ack && a1c < 0) a1c = c;
      @(posedge clk); #1;
      if (a0c >= 0) m0_stb = 1'b0;
      if (a1c >= 0) m1_stb = 1'b0;
    end
    chk("cont_grant_m0", 32'(g[1]), 32'h1);
    chk("cont_m0_ack_cycle", 32'(a0c), 32'd3);
    chk("cont_idle_grant", 32'(g[4]), 32'h0);
    chk("cont_grant_m1", 32'(g[5]), 32'h2);
    chk("cont_m1_ack_cycle", 32'(a1c), 32'd7);
    mptr = 0;
  endtask

  task automatic seq_abort();
    logic       ss[13];
    logic       bs[13];
    logic [1:0] g[13];
    bit         m0_acked = 1'b0;
    int         a1c = -1;
    logic [31:0] d1 = 'x;
    slv_lat = 255; slv_data = 32'hFACE_0029;
    m0_adr = 32'h10; m0_we = 1'b1; m1_we = 1'b0;
    m0_stb = 1'b1; m1_stb = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      ss[c] = s_stb; bs[c] = busy; g[c] = grant;
      if (m0_ack || m0_err) m0_acked = 1'b1;
      if (m1_ack && a1c < 0) begin a1c = c; d1 = m1_dat_o; end
      @(posedge clk); #1;
      if (c + 1 == 1) m1_stb = 1'b1;
      if (c + 1 == 2) m0_stb = 1'b0;
      if (c + 1 == 3) slv_lat = 1;
      if (a1c >= 0) m1_stb = 1'b0;
    end
    chk("abort_stb_busy2", 32'(ss[2]), 32'd1);
    chk("abort_stb_low", 32'(ss[3]), 32'd0);
    chk("abort_done_busy", 32'(bs[3]), 32'd1);
    chk("abort_done_grant", 32'(g[3]), 32'h1);
    chk("abort_no_m0_ack", 32'(m0_acked), 32'd0);
    chk("abort_m1_grant", 32'(g[5]), 32'h2);
    chk("abort_m1_ack_cycle", 32'(a1c), 32'd7);
    chk("abort_m1_dat", d1, 32'hFACE_0029);
    mptr = 0;
  endtask

  task automatic seq_reset();
    bit quiet = 1'b1;
    slv_lat = 255;
    m0_adr = 32'h10; m0_dat_i = 32'hA5A5_0001; m0_we = 1'b1;
    m0_stb = 1'b1; m1_stb = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(posedge clk); #2;
    chk("prerst_stb", 32'(s_stb), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_stb", 32'(s_stb), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_s_adr", s_adr, 32'h0);
    chk("midrst_s_we", 32'(s_we), 32'd0);
    chk("midrst_dat_o", m0_dat_o, 32'h0);
    m0_stb = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m0_ack || m0_err || m1_ack || m1_err || busy || s_stb) quiet = 1'b0;
    end
    chk("postrst_quiet", 32'(quiet), 32'd1);
    @(posedge clk); #1;
    mptr = 0;
  endtask

  initial begin
    tbl[0] = mk(1'b1, 1'b1, 1'b1, 1'b0,   1, 32'h1111_0000, 0,  3, 1'b0);
    tbl[1] = mk(1'b1, 1'b0, 1'b1, 1'b0,   1, 32'h2222_0001, 0,  3, 1'b0);
    tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0,   1, 32'hDEAD_0042, 1,  3, 1'b0);
    tbl[3] = mk(1'b1, 1'b1, 1'b0, 1'b1,   0, 32'h3333_0003, 0,  2, 1'b0);
    tbl[4] = mk(1'b1, 1'b1, 1'b1, 1'b1,   2, 32'h4444_0004, 1,  4, 1'b0);
    tbl[5] = mk(1'b0, 1'b1, 1'b0, 1'b1,  15, 32'h5555_0005, 1, 17, 1'b0);
    tbl[6] = mk(1'b1, 1'b1, 1'b0, 1'b0,  16, 32'h6666_0006, 0, 17, 1'b1);
    tbl[7] = mk(1'b1, 1'b0, 1'b1, 1'b0,   3, 32'h7777_0007, 0,  5, 1'b0);
    tbl[8] = mk(1'b1, 1'b1, 1'b1, 1'b0,   1, 32'h8888_0008, 1,  3, 1'b0);
    tbl[9] = mk(1'b1, 1'b0, 1'b0, 1'b0, 255, 32'h9999_0009, 0, 17, 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_stb", 32'(s_stb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_acks", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    chk("rst_s_adr", s_adr, 32'h0);
    chk("rst_s_dat_o", s_dat_o, 32'h0);
    chk("rst_s_we", 32'(s_we), 32'd0);
    chk("rst_dat_o", m0_dat_o | m1_dat_o, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    seq_contention();

    m0_adr = 32'h10; m0_dat_i = 32'hA5A5_0001;
    m1_adr = 32'h20; m1_dat_i = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) xfer(tbl[i], $sformatf("vec%0d", i));

    seq_abort();
    seq_reset();

    // Model: lone requester wins, else the pointer; ack lands lat+2 cycles
    // after the request unless the slave is slower than TO BUSY cycles.
    for (int i = 0; i < 30; i++) begin
      vec_t v;
      bit r0, r1, we0, we1, err;
      int lat, who, cyc;
      logic [31:0] rd;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      lat = int'($urandom_range(0, 20));
      rd  = $urandom;
      m0_adr = $urandom; m0_dat_i = $urandom;
      m1_adr = $urandom; m1_dat_i = $urandom;
      who = (r0 && r1) ? mptr : (r1 ? 1 : 0);
      err = (lat >= TO);
      cyc = err ? TO + 1 : lat + 2;
      v = mk(r0, r1, we0, we1, lat, rd, who, cyc, err);
      xfer(v, $sformatf("rnd%0d", i));
      mptr = (who == 1) ? 0 : 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mailbox_arb.md
MAILBOX_ARB -- requirements
Module: mailbox_arb

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, 16, BUSY cycles allowed before an abort; legal range 2..255.
REQ-002 The port list SHALL begin: clk  in  1  single clock, all state updates on its rising edge.
REQ-003 The port list SHALL continue: reset  in  1  asynchronous, active-high reset.
REQ-004 The master ports SHALL be, for n = 0,1: mn_stb in 1, mn_we in 1, mn_dat_i in 32, mn_adr in 32; mn_ack out 1, mn_err out 1, mn_dat_o out 32.
REQ-005 The slave ports SHALL be: s_stb out 1, s_we out 1, s_dat_o out 32, s_adr out 32; s_ack in 1, s_dat_i in 32.
REQ-006 The status ports SHALL be: busy out 1 (high outside IDLE), grant out 2 (one-hot owner, 00 when none).

Function
REQ-007 The arbiter SHALL share one Wishbone-classic slave (the mailbox device) between two masters through states IDLE, BUSY and DONE.
REQ-008 In IDLE with at least one mn_stb high, the arbiter SHALL grant one master and register its we/dat_i/adr into s_we/s_dat_o/s_adr, entering BUSY on the next edge.
REQ-009 When both masters request in the same IDLE cycle, the arbiter SHALL grant the master indicated by a 1-bit priority pointer (reset 0).
REQ-010 After a completed or aborted transfer, the pointer SHALL point to the other master.
REQ-011 s_stb SHALL be high exactly while in BUSY, with the slave address, data and we held constant throughout BUSY.
REQ-012 In BUSY, when s_ack is sampled high, the arbiter SHALL register s_dat_i into the shared read register and enter DONE.
REQ-013 On that edge, the arbiter SHALL set the granted mn_ack high for exactly one cycle, with mn_err low.
REQ-014 mn_dat_o SHALL equal the shared read register for both masters; it is valid only while the corresponding mn_ack is high.
REQ-015 A timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without s_ack.
REQ-016 When the timeout counter reaches TIMEOUT-1 with s_ack low, the arbiter SHALL pulse mn_ack and mn_err together for one cycle, load the read register with 32'h0, and enter DONE.
REQ-017 If s_ack and the timeout coincide, the arbiter SHALL complete normally with mn_err low.
REQ-018 If the granted mn_stb drops while in BUSY, the arbiter SHALL abort: no ack is issued, the read register is unchanged, and the state goes to DONE.
REQ-019 DONE SHALL last exactly one cycle with s_stb low, ignore all requests, and then return to IDLE.
REQ-020 Minimum latency SHALL be: request in IDLE at cycle 0, s_stb high at cycle 1, mn_ack at cycle 3 for a slave that acks one cycle after stb.
REQ-021 The non-granted master SHALL see mn_ack and mn_err stay low, and its request SHALL remain pending with no loss.
REQ-022 grant SHALL be registered and valid during BUSY and DONE.

Reset
REQ-023 Asserting reset at any time, including mid-BUSY, SHALL immediately force state IDLE, with no further ack pulse after release.
REQ-024 During reset, the arbiter SHALL drive s_stb=0, s_we=0, s_adr=0, s_dat_o=0, all mn_ack=0, all mn_err=0, read register 0, mn_dat_o=0, pointer=0, counter=0, busy=0 and grant=00.

Verification
REQ-025 The bench SHALL check a single write: m0 write adr=32'h10, dat=32'hA5A5_0001, slave acks one cycle after s_stb -> s_adr/s_dat_o match, m0_ack one cycle pulse at cycle 3, m0_err=0, m1_ack stays 0.
REQ-026 The bench SHALL check contention: m0 and m1 request together out of reset -> m0 served first, m1 is granted on the IDLE following m0's DONE, and the pointer ends at 0.
REQ-027 The bench SHALL check a read: m1 read with the slave returning 32'hDEAD_0042 -> m1_dat_o=32'hDEAD_0042 while m1_ack=1.
REQ-028 The bench SHALL check timeout: slave never acks, TIMEOUT=16 -> m0_ack=m0_err=1 for one cycle after 16 BUSY cycles, m0_dat_o=0, busy low two cycles later.
REQ-029 The bench SHALL check abort: m0 drops stb in the second BUSY cycle -> s_stb low next cycle, no m0_ack, and a pending m1 is granted afterwards.
REQ-030 The bench SHALL check reset mid-BUSY: asserting reset asynchronously -> s_stb, busy and grant go 0 before the next clock edge, and no ack follows release.
